// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver on an oversampling strobe: input synchronizer, 2-of-3 majority vote,
// false-start rejection, and registered done / framing-error pulses.
module uart_rx_oversampled #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICK    = 16
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err_tick,
  output logic [1:0]      rx_state
);

  localparam int unsigned SMAX   = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int unsigned SCNT_W = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int unsigned NCNT_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SCNT_W-1:0] S_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] S_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [SCNT_W-1:0] S_STOP = SCNT_W'(SB_TICK - 1);
  localparam logic [NCNT_W-1:0] N_LAST = NCNT_W'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [SCNT_W-1:0] s_cnt, s_cnt_n;
  logic [NCNT_W-1:0] n_cnt, n_cnt_n;
  logic [DBIT-1:0]   shreg, shreg_n;
  logic [DBIT-1:0]   dout_n;
  logic              done_n, ferr_n;
  logic              rx_meta, rx_s;
  logic [1:0]        samp;
  logic              maj;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Vote history; only the two most recent samples join the current one in the vote
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      samp <= 2'b11;
    end else if (s_tick) begin
      samp <= {samp[0], rx_s};
    end
  end

  assign maj = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);

  // State, counters, shift register and registered outputs
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state          <= IDLE;
      s_cnt          <= '0;
      n_cnt          <= '0;
      shreg          <= '0;
      dout           <= '0;
      rx_done_tick   <= 1'b0;
      frame_err_tick <= 1'b0;
    end else begin
      state          <= state_n;
      s_cnt          <= s_cnt_n;
      n_cnt          <= n_cnt_n;
      shreg          <= shreg_n;
      dout           <= dout_n;
      rx_done_tick   <= done_n;
      frame_err_tick <= ferr_n;
    end
  end

  // Next-state and frame decoding
  always_comb begin
    state_n = state;
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    shreg_n = shreg;
    dout_n  = dout;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_cnt_n = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == S_MID) begin
            s_cnt_n = '0;
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              n_cnt_n = '0;
            end
          end else begin
            s_cnt_n = s_cnt + SCNT_W'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == S_LAST) begin
            s_cnt_n = '0;
            shreg_n = {maj, shreg[DBIT-1:1]};
            if (n_cnt == N_LAST) begin
              state_n = STOP;
            end else begin
              n_cnt_n = n_cnt + NCNT_W'(1);
            end
          end else begin
            s_cnt_n = s_cnt + SCNT_W'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt == S_STOP) begin
            state_n = IDLE;
            s_cnt_n = '0;
            if (maj) begin
              dout_n = shreg;
              done_n = 1'b1;
            end else begin
              ferr_n = 1'b1;
            end
          end else begin
            s_cnt_n = s_cnt + SCNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_state = state;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: s_tick every 4 clocks, 64 clocks per bit.
module tb_uart_rx_oversampled;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx     = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err_tick;
  logic [1:0] rx_state;

  int unsigned tcnt = 0;
  int tests = 0;
  int fails = 0;

  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         long_cnt = 0;
  logic       prev_done = 1'b0;
  logic       prev_ferr = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_oversampled #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
    .clock_i       (clk),
    .reset_i       (rst_n),
    .s_tick        (s_tick),
    .rx            (rx),
    .dout          (dout),
    .rx_done_tick  (rx_done_tick),
    .frame_err_tick(frame_err_tick),
    .rx_state      (rx_state)
  );

  // Clock and baud strobe; s_tick is high for one posedge out of every four
  initial begin
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
      tcnt = tcnt + 1;
      s_tick = (tcnt % 4 == 0);
    end
  end

  // Pulse recorder, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt = done_cnt + 1;
      got_q.push_back(dout);
    end
    if (frame_err_tick) ferr_cnt = ferr_cnt + 1;
    if (rx_done_tick && frame_err_tick) both_cnt = both_cnt + 1;
    if ((rx_done_tick && prev_done) || (frame_err_tick && prev_ferr)) long_cnt = long_cnt + 1;
    prev_done = rx_done_tick;
    prev_ferr = frame_err_tick;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Leaves the bench just before a posedge that carries s_tick
  task automatic align_tick();
    int guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (!s_tick && guard < 8);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(64);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (stop) begin
      send_bit(1'b1);
    end else begin
      rx = 1'b0;
      wait_clk(48);
      rx = 1'b1;
      wait_clk(16);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout got=%h exp=00", dout); end
    tests++; if (rx_done_tick !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", rx_done_tick); end
    tests++; if (frame_err_tick !== 1'b0) begin fails++; $display("FAIL reset_ferr got=%b exp=0", frame_err_tick); end
    tests++; if (rx_state !== 2'd0) begin fails++; $display("FAIL reset_state got=%0d exp=0", rx_state); end
    rst_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    got_q.delete();
    align_tick();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_clk(20);
        tests++; if (rx_state !== 2'd1) begin fails++; $display("FAIL single_state_start got=%0d exp=1", rx_state); end
        wait_clk(180);
        tests++; if (rx_state !== 2'd2) begin fails++; $display("FAIL single_state_data got=%0d exp=2", rx_state); end
        wait_clk(380);
        tests++; if (rx_state !== 2'd3) begin fails++; $display("FAIL single_state_stop got=%0d exp=3", rx_state); end
      end
    join
    wait_clk(20);
    tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL single_pulses got=%0d exp=1", done_cnt - d0); end
    tests++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin fails++; $display("FAIL single_byte got=%p exp=A5", got_q); end
    tests++; if (ferr_cnt - f0 !== 0) begin fails++; $display("FAIL single_ferr got=%0d exp=0", ferr_cnt - f0); end
    tests++; if (dout !== 8'hA5) begin fails++; $display("FAIL single_dout got=%h exp=A5", dout); end
    tests++; if (rx_state !== 2'd0) begin fails++; $display("FAIL single_idle got=%0d exp=0", rx_state); end
  endtask

  task automatic test_frame_error();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    align_tick();
    send_frame(8'h3C, 1'b0);
    wait_clk(60);
    tests++; if (ferr_cnt - f0 !== 1) begin fails++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0); end
    tests++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL ferr_done got=%0d exp=0", done_cnt - d0); end
    tests++; if (dout !== 8'hA5) begin fails++; $display("FAIL ferr_dout got=%h exp=A5", dout); end
    tests++; if (rx_state !== 2'd0) begin fails++; $display("FAIL ferr_idle got=%0d exp=0", rx_state); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    int d0 = done_cnt;
    exp_b[0] = 8'h78; exp_b[1] = 8'h56; exp_b[2] = 8'h34; exp_b[3] = 8'h12;
    got_q.delete();
    align_tick();
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1);
    wait_clk(20);
    tests++; if (done_cnt - d0 !== 4) begin fails++; $display("FAIL b2b_pulses got=%0d exp=4", done_cnt - d0); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_q.size() <= i || got_q[i] !== exp_b[i]) begin
        fails++; $display("FAIL b2b_byte%0d got=%p exp=%h", i, got_q, exp_b[i]);
      end
    end
    tests++; if (dout !== 8'h12) begin fails++; $display("FAIL b2b_dout got=%h exp=12", dout); end
  endtask

  task automatic test_false_start();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    align_tick();
    rx = 1'b0;
    wait_clk(10);
    tests++; if (rx_state !== 2'd1) begin fails++; $display("FAIL fstart_state got=%0d exp=1", rx_state); end
    wait_clk(6);
    rx = 1'b1;
    wait_clk(40);
    tests++; if (rx_state !== 2'd0) begin fails++; $display("FAIL fstart_idle got=%0d exp=0", rx_state); end
    tests++; if ((done_cnt - d0) + (ferr_cnt - f0) !== 0) begin
      fails++; $display("FAIL fstart_pulses got=%0d exp=0", (done_cnt - d0) + (ferr_cnt - f0));
    end
    got_q.delete();
    align_tick();
    send_frame(8'h3C, 1'b1);
    wait_clk(20);
    tests++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin fails++; $display("FAIL fstart_next got=%p exp=3C", got_q); end
    tests++; if (dout !== 8'h3C) begin fails++; $display("FAIL fstart_dout got=%h exp=3C", dout); end
  endtask

  task automatic test_glitch();
    int d0 = done_cnt;
    got_q.delete();
    align_tick();
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      rx = 1'b0;
      if (i == 3) begin
        wait_clk(25); rx = 1'b1; wait_clk(4); rx = 1'b0; wait_clk(35);
      end else if (i == 6) begin
        wait_clk(29); rx = 1'b1; wait_clk(4); rx = 1'b0; wait_clk(31);
      end else begin
        wait_clk(64);
      end
    end
    send_bit(1'b1);
    wait_clk(20);
    tests++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL glitch_pulses got=%0d exp=1", done_cnt - d0); end
    tests++; if (dout !== 8'h00) begin fails++; $display("FAIL glitch_dout got=%h exp=00", dout); end
  endtask

  task automatic test_reset_midframe();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    align_tick();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_clk(200);
        tests++; if (rx_state !== 2'd2) begin fails++; $display("FAIL rstmid_pre got=%0d exp=2", rx_state); end
        rst_n = 1'b0;
        #1;
        tests++; if (rx_state !== 2'd0) begin fails++; $display("FAIL rstmid_state got=%0d exp=0", rx_state); end
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL rstmid_dout got=%h exp=00", dout); end
        tests++; if (rx_done_tick !== 1'b0 || frame_err_tick !== 1'b0) begin
          fails++; $display("FAIL rstmid_pulses got=%b%b exp=00", rx_done_tick, frame_err_tick);
        end
        wait_clk(10);
        rst_n = 1'b1;
      end
    join
    wait_clk(20);
    tests++; if ((done_cnt - d0) + (ferr_cnt - f0) !== 0) begin
      fails++; $display("FAIL rstmid_nopulse got=%0d exp=0", (done_cnt - d0) + (ferr_cnt - f0));
    end
    got_q.delete();
    align_tick();
    send_frame(8'h5A, 1'b1);
    wait_clk(20);
    tests++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin fails++; $display("FAIL rstmid_next got=%p exp=5A", got_q); end
    tests++; if (dout !== 8'h5A) begin fails++; $display("FAIL rstmid_dout2 got=%h exp=5A", dout); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame_error();
    test_back_to_back();
    test_false_start();
    test_glitch();
    test_reset_midframe();
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL pulse_exclusive got=%0d exp=0", both_cnt); end
    tests++; if (long_cnt !== 0) begin fails++; $display("FAIL pulse_width got=%0d exp=0", long_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
